// File: rtl/alu_op_queue.sv
// rtl/alu_op_queue.sv - operation FIFO and result skid register around a combinational ALU
//
// Buffers {ctrl, a, b} operations in a DEPTH-entry FIFO, presents the head
// entry to an external combinational ALU, and captures the ALU result and
// flags into a one-entry result register in the cycle the head is issued.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              producer handshake
//   in_ctrl, in_a, in_b            operation offered by the producer
//   alu_ctrl, alu_a, alu_b         head entry driven to the ALU (zeros when empty)
//   alu_out, alu_carry, alu_zero   ALU response to alu_*
//   res_valid/res_ready            consumer handshake
//   res_data, res_carry, res_zero  registered ALU result
//   count                          FIFO occupancy, 0..DEPTH
module alu_op_queue #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_ctrl,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [3:0]               alu_ctrl,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_carry,
  output logic                     res_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 4 + 2 * WIDTH;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          issue;

  // Both handshake outputs come from registered state only, so there is
  // no combinational path from res_ready to in_ready.
  assign in_ready = (count < FULL);
  assign push     = in_valid & in_ready;

  // The head is consumed whenever the result register is free or being
  // drained this cycle; a push into an empty FIFO is not visible here until
  // the next cycle, so there is no flow-through.
  assign issue = (count != '0) & (~res_valid | res_ready);

  assign head = (count != '0) ? mem[rd_ptr] : '0;
  assign {alu_ctrl, alu_a, alu_b} = head;

  // Storage contents need no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_ctrl, in_a, in_b};
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push & ~issue) begin
        count <= count + 1'b1;
      end else if (issue & ~push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Result skid register: reloaded on issue, otherwise data holds and only
  // the valid bit drops once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_carry <= alu_carry;
      res_zero  <= alu_zero;
    end else if (res_valid & res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_queue.sv
// tb/tb_alu_op_queue.sv - self-checking bench for alu_op_queue
module tb_alu_op_queue;

  localparam int W = 6;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ctrl;
  logic [W-1:0] in_a, in_b;
  logic [3:0] alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic       alu_carry, alu_zero;
  logic       res_valid, res_ready;
  logic [W-1:0] res_data;
  logic       res_carry, res_zero;
  logic [2:0] count;

  always #5 clk = ~clk;

  alu_op_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
    .count(count)
  );

  // ALU stand-in: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, others give 0.
  // Returns {zero, carry, result}.
  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    logic [5:0] r;
    logic       cy;
    cy = 1'b0;
    s  = '0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = s[5:0]; cy = s[6]; end
      4'b0011: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 6'd0), cy, r};
  endfunction

  assign {alu_zero, alu_carry, alu_out} = alu_f(alu_ctrl, alu_a, alu_b);

  typedef struct packed {
    logic [3:0] c;
    logic [5:0] a;
    logic [5:0] b;
  } op_t;

  typedef struct {
    logic [3:0] c;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] d;
    logic       cy;
    logic       z;
  } vec_t;

  // Reference model: the FIFO as a queue plus the result slot.
  op_t        mq[$];
  bit         m_rv;
  logic [7:0] m_res;
  bit         acc;
  bit         dut_acc;
  int         errors = 0;
  int         checks = 0;
  int         max_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare DUT with the model, drive inputs, advance the model.
  // Called just after a falling edge and returns after the next one.
  task automatic cyc(input bit r, input bit v, input op_t op, input bit rr);
    op_t h;
    bit  iss;
    bit  psh;
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < D));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_data", 32'(res_data), 32'(m_res[5:0]));
    chk("res_carry", 32'(res_carry), 32'(m_res[6]));
    chk("res_zero", 32'(res_zero), 32'(m_res[7]));
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("alu_head", 32'({alu_ctrl, alu_a, alu_b}), 32'(h));
    if (int'(count) > max_count) max_count = int'(count);
    dut_acc = v && in_ready;
    rst = r;
    in_valid = v;
    {in_ctrl, in_a, in_b} = op;
    res_ready = rr;
    acc = 1'b0;
    if (r) begin
      mq.delete();
      m_rv = 1'b0;
      m_res = '0;
    end else begin
      iss = (mq.size() != 0) && (!m_rv || rr);
      psh = v && (mq.size() < D);
      if (iss) begin
        m_res = alu_f(mq[0].c, mq[0].a, mq[0].b);
        m_rv = 1'b1;
        void'(mq.pop_front());
      end else if (m_rv && rr) begin
        m_rv = 1'b0;
      end
      if (psh) mq.push_back(op);
      acc = psh;
    end
    @(negedge clk);
  endtask

  function automatic op_t rnd_op();
    op_t o;
    o.c = 4'($urandom_range(0, 15));
    o.a = 6'($urandom);
    o.b = 6'($urandom);
    return o;
  endfunction

  vec_t tbl[7];
  op_t  o;
  op_t  ob;
  int   n_acc;
  int   pushed;
  int   guard;

  initial begin
    tbl[0] = '{4'b0010, 6'd5,   6'd3,   6'd8,   1'b0, 1'b0};
    tbl[1] = '{4'b0010, 6'd63,  6'd1,   6'd0,   1'b1, 1'b1};
    tbl[2] = '{4'b0000, 6'h2A,  6'h0F,  6'h0A,  1'b0, 1'b0};
    tbl[3] = '{4'b0001, 6'h21,  6'h12,  6'h33,  1'b0, 1'b0};
    tbl[4] = '{4'b0011, 6'h15,  6'h15,  6'h00,  1'b0, 1'b1};
    tbl[5] = '{4'b0010, 6'd40,  6'd30,  6'd6,   1'b1, 1'b0};
    tbl[6] = '{4'b0000, 6'h30,  6'h0C,  6'h00,  1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_a = '0; in_b = '0; res_ready = 1'b0;
    m_rv = 1'b0; m_res = '0;
    @(negedge clk);
    @(negedge clk);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Table vectors: push into an empty queue, result visible two edges later.
    for (int i = 0; i < 7; i++) begin
      o = '{tbl[i].c, tbl[i].a, tbl[i].b};
      cyc(1'b0, 1'b1, o, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk($sformatf("vec%0d_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_carry", i), 32'(res_carry), 32'(tbl[i].cy));
      chk($sformatf("vec%0d_zero", i), 32'(res_zero), 32'(tbl[i].z));
    end
    cyc(1'b0, 1'b0, '0, 1'b1);

    // Back-pressure: six offers with res_ready low, five land.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      o = '{4'b0010, 6'(i * 9 + 1), 6'(i + 2)};
      cyc(1'b0, 1'b1, o, 1'b0);
      if (dut_acc) n_acc++;
    end
    chk("bp_accepted", 32'(n_acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd4);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-stream with three ops queued and a pending result.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, rnd_op(), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu", 32'({alu_ctrl, alu_a, alu_b}), 32'd0);

    // Wrap-around: ten logic ops with idle cycles and random back-pressure.
    max_count = 0;
    pushed = 0;
    guard = 0;
    while (pushed < 10 && guard < 300) begin
      case (pushed % 3)
        0: o.c = 4'b0011;
        1: o.c = 4'b0001;
        default: o.c = 4'b0000;
      endcase
      o.a = 6'(pushed * 5 + 1);
      o.b = 6'(pushed * 7 + 2);
      cyc(1'b0, ($urandom_range(0, 3) != 0), o, ($urandom_range(0, 2) != 0));
      if (acc) pushed++;
      guard++;
    end
    chk("wrap_pushed", 32'(pushed), 32'd10);
    guard = 0;
    while ((mq.size() != 0 || m_rv) && guard < 50) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    chk("wrap_drained", 32'(res_valid), 32'd0);
    chk("wrap_max_count_le4", 32'(max_count <= D), 32'd1);

    // Simultaneous push and issue at count=2.
    ob = '{4'b0010, 6'd20, 6'd22};
    cyc(1'b0, 1'b1, '{4'b0001, 6'd1, 6'd2}, 1'b0);
    cyc(1'b0, 1'b1, ob, 1'b0);
    cyc(1'b0, 1'b1, '{4'b0011, 6'd7, 6'd9}, 1'b0);
    chk("sim_count_before", 32'(count), 32'd2);
    cyc(1'b0, 1'b1, '{4'b0000, 6'd60, 6'd15}, 1'b1);
    chk("sim_count_after", 32'(count), 32'd2);
    chk("sim_res_data", 32'(res_data), 32'd42);
    chk("sim_res_zero", 32'(res_zero), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1);

    // Random traffic including unused control codes and occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), rnd_op(), ($urandom_range(0, 2) != 0));
    end
    cyc(1'b0, 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
